// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer driven by an external one-second tick level.
// Holds binary min/sec, exposes them as four BCD digits, and raises done/alarm at 0:00.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; time may be loaded, start runs if time is nonzero
// ST_RUN   | counting down one second per rising edge of tick
// ST_PAUSE | countdown frozen; start resumes, load returns to IDLE
// ST_DONE  | reached 0:00; alarm high until start acknowledges
module countdown_timer #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [5:0]  load_min,
  input  logic [5:0]  load_sec,
  input  logic        start,
  input  logic        pause,
  input  logic        cancel,
  output logic [1:0]  state,
  output logic [15:0] bcd,
  output logic        done,
  output logic        alarm
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] MAX_MIN_C = 6'(MAX_MIN);
  localparam logic [5:0] MAX_SEC_C = 6'd59;

  state_t     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       tick_d_q, tick_d_d;
  logic       done_q, done_d;
  logic       tick_edge;
  logic       time_zero;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if      (v >= 6'd60) tens = 4'd6;
    else if (v >= 6'd50) tens = 4'd5;
    else if (v >= 6'd40) tens = 4'd4;
    else if (v >= 6'd30) tens = 4'd3;
    else if (v >= 6'd20) tens = 4'd2;
    else if (v >= 6'd10) tens = 4'd1;
    else                 tens = 4'd0;
    ones = 4'(v - 6'(tens) * 6'd10);
    return {tens, ones};
  endfunction

  assign tick_edge = tick & ~tick_d_q;
  assign time_zero = (min_q == 6'd0) && (sec_q == 6'd0);

  // tick_d resets high so a tick already asserted at reset release is not counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      tick_d_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      tick_d_q <= tick_d_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    tick_d_d = tick;

    if (cancel) begin
      state_d = ST_IDLE;
      min_d   = 6'd0;
      sec_d   = 6'd0;
    end else if (load && (state_q != ST_RUN)) begin
      state_d = ST_IDLE;
      min_d   = (load_min > MAX_MIN_C) ? MAX_MIN_C : load_min;
      sec_d   = (load_sec > MAX_SEC_C) ? MAX_SEC_C : load_sec;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!pause && start && !time_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick_edge && !time_zero) begin
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              sec_d = MAX_SEC_C;
              min_d = min_q - 6'd1;
            end
            // reaching 0:00 wins over a pause in the same cycle
            if ((min_d == 6'd0) && (sec_d == 6'd0)) state_d = ST_DONE;
            else if (pause)                          state_d = ST_PAUSE;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause && start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (!pause && start) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_comb begin
    state = state_q;
    bcd   = {to_bcd(min_q), to_bcd(sec_q)};
    done  = done_q;
    alarm = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expectations queued with each stimulus step
// and popped/compared once the DUT has responded.
module tb_countdown_timer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        load;
  logic [5:0]  load_min;
  logic [5:0]  load_sec;
  logic        start;
  logic        pause;
  logic        cancel;
  logic [1:0]  state;
  logic [15:0] bcd;
  logic        done;
  logic        alarm;

  always #5 clk = ~clk;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .cancel   (cancel),
    .state    (state),
    .bcd      (bcd),
    .done     (done),
    .alarm    (alarm)
  );

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [15:0] bcd;
    logic        dn;
    logic        al;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int dc;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic [15:0] b,
                            input logic dn, input logic al);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.bcd = b;
    e.dn  = dn;
    e.al  = al;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_underflow observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    assert (state === e.st) else begin
      fails++;
      $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
    end
    tests++;
    assert (bcd === e.bcd) else begin
      fails++;
      $error("FAIL %s.bcd observed=%h expected=%h", e.tag, bcd, e.bcd);
    end
    tests++;
    assert (done === e.dn) else begin
      fails++;
      $error("FAIL %s.done observed=%b expected=%b", e.tag, done, e.dn);
    end
    tests++;
    assert (alarm === e.al) else begin
      fails++;
      $error("FAIL %s.alarm observed=%b expected=%b", e.tag, alarm, e.al);
    end
  endtask

  // hold tick high for n more cycles, then drop it and idle a few cycles
  task automatic tick_hold(input int n);
    repeat (n) step();
    tick = 1'b0;
    repeat (5) step();
  endtask

  task automatic do_load(input string tag, input logic [5:0] m, input logic [5:0] s,
                         input logic [15:0] exp_bcd);
    load_min = m;
    load_sec = s;
    load = 1'b1;
    expect_out(tag, S_IDLE, exp_bcd, 1'b0, 1'b0);
    step();
    load = 1'b0;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; load = 1'b0; load_min = 6'd0; load_sec = 6'd0;
    start = 1'b0; pause = 1'b0; cancel = 1'b0;
    step(); step();
    expect_out("reset", S_IDLE, 16'h0000, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1;
    expect_out("post_reset", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step();
    check_out();

    // 0:03 full countdown to DONE and acknowledge
    do_load("t1_load", 6'd0, 6'd3, 16'h0003);
    start = 1'b1;
    expect_out("t1_start", S_RUN, 16'h0003, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    dc = done_cnt;
    tick = 1'b1;
    expect_out("t1_tick1", S_RUN, 16'h0002, 1'b0, 1'b0);
    step(); check_out();
    expect_out("t1_hold1", S_RUN, 16'h0002, 1'b0, 1'b0);
    tick_hold(49); check_out();
    tick = 1'b1;
    expect_out("t1_tick2", S_RUN, 16'h0001, 1'b0, 1'b0);
    step(); check_out();
    tick_hold(49);
    tick = 1'b1;
    expect_out("t1_tick3", S_DONE, 16'h0000, 1'b1, 1'b1);
    step(); check_out();
    expect_out("t1_done_next", S_DONE, 16'h0000, 1'b0, 1'b1);
    step(); check_out();
    expect_out("t1_alarm_hold", S_DONE, 16'h0000, 1'b0, 1'b1);
    tick_hold(48); check_out();
    tests++;
    assert (done_cnt - dc == 1) else begin
      fails++;
      $error("FAIL t1_done_pulses observed=%0d expected=1", done_cnt - dc);
    end
    start = 1'b1;
    expect_out("t1_ack", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();

    // load ignored in RUN, minute borrow 1:00 -> 0:59
    do_load("t2_load", 6'd1, 6'd0, 16'h0100);
    start = 1'b1;
    expect_out("t2_start", S_RUN, 16'h0100, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    load_min = 6'd5; load_sec = 6'd30; load = 1'b1; tick = 1'b1;
    expect_out("t2_load_run_tick", S_RUN, 16'h0059, 1'b0, 1'b0);
    step(); load = 1'b0; check_out();
    expect_out("t2_hold", S_RUN, 16'h0059, 1'b0, 1'b0);
    tick_hold(49); check_out();
    load = 1'b1;
    expect_out("t2_load_run", S_RUN, 16'h0059, 1'b0, 1'b0);
    step(); load = 1'b0; check_out();
    cancel = 1'b1;
    expect_out("t2_cancel", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); cancel = 1'b0; check_out();

    // pause together with a tick edge, ticks while paused, resume
    do_load("t3_load", 6'd0, 6'd5, 16'h0005);
    start = 1'b1;
    expect_out("t3_start", S_RUN, 16'h0005, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    pause = 1'b1; tick = 1'b1;
    expect_out("t3_pause_tick", S_PAUSE, 16'h0004, 1'b0, 1'b0);
    step(); pause = 1'b0; check_out();
    tick_hold(49);
    tick = 1'b1;
    expect_out("t3_tick_paused", S_PAUSE, 16'h0004, 1'b0, 1'b0);
    step(); check_out();
    tick_hold(49);
    start = 1'b1;
    expect_out("t3_resume", S_RUN, 16'h0004, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    tick = 1'b1;
    expect_out("t3_tick_run", S_RUN, 16'h0003, 1'b0, 1'b0);
    step(); check_out();
    tick_hold(49);
    cancel = 1'b1;
    expect_out("t3_cancel", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); cancel = 1'b0; check_out();

    // load saturation and start at 0:00
    do_load("t4_sat", 6'd63, 6'd63, 16'h5959);
    cancel = 1'b1;
    expect_out("t4_cancel", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); cancel = 1'b0; check_out();
    start = 1'b1;
    expect_out("t4_start_zero", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();

    // cancel beats the final tick edge: no done
    do_load("t5_load", 6'd0, 6'd1, 16'h0001);
    start = 1'b1;
    expect_out("t5_start", S_RUN, 16'h0001, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    dc = done_cnt;
    tick = 1'b1; cancel = 1'b1;
    expect_out("t5_cancel_tick", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); cancel = 1'b0; check_out();
    expect_out("t5_idle", S_IDLE, 16'h0000, 1'b0, 1'b0);
    tick_hold(49); check_out();
    tests++;
    assert (done_cnt == dc) else begin
      fails++;
      $error("FAIL t5_no_done observed=%0d expected=0", done_cnt - dc);
    end

    // final tick with pause still goes to DONE
    do_load("t7_load", 6'd0, 6'd1, 16'h0001);
    start = 1'b1;
    expect_out("t7_start", S_RUN, 16'h0001, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    tick = 1'b1; pause = 1'b1;
    expect_out("t7_pause_final", S_DONE, 16'h0000, 1'b1, 1'b1);
    step(); pause = 1'b0; check_out();
    tick_hold(10);
    start = 1'b1;
    expect_out("t7_ack", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();

    // reset mid-RUN with tick held high
    do_load("t6_load", 6'd0, 6'd5, 16'h0005);
    start = 1'b1;
    expect_out("t6_start", S_RUN, 16'h0005, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    tick = 1'b1;
    expect_out("t6_tick", S_RUN, 16'h0004, 1'b0, 1'b0);
    step(); check_out();
    repeat (10) step();
    rst_n = 1'b0;
    expect_out("t6_reset", S_IDLE, 16'h0000, 1'b0, 1'b0);
    step(); rst_n = 1'b1; check_out();
    do_load("t6_reload", 6'd0, 6'd5, 16'h0005);
    start = 1'b1;
    expect_out("t6_restart", S_RUN, 16'h0005, 1'b0, 1'b0);
    step(); start = 1'b0; check_out();
    expect_out("t6_no_dec", S_RUN, 16'h0005, 1'b0, 1'b0);
    repeat (20) step();
    check_out();
    tick = 1'b0; step();
    tick = 1'b1;
    expect_out("t6_fresh_tick", S_RUN, 16'h0004, 1'b0, 1'b0);
    step(); check_out();
    tick_hold(10);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
